// File: rtl/cam_pkg.sv
// Shared types and AXI constants for the camera frame write controller.
package cam_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_DATA = 3'd1,
    ADDR      = 3'd2,
    DATA      = 3'd3,
    RESP      = 3'd4
  } cam_state_e;

  localparam logic [2:0]  AXSIZE_4B      = 3'b010;
  localparam logic [1:0]  AXBURST_INCR   = 2'b01;
  localparam logic [1:0]  RESP_OKAY      = 2'b00;
  localparam int unsigned BYTES_PER_WORD = 4;

  // Counter width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cam_vsync_edge.sv
// VSYNC history flop and rising-edge detect; history resets high so a VSYNC
// already asserted when reset releases is not mistaken for a frame start.
module cam_vsync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic vsync_i,
  output logic rise_o
);

  logic vsync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vsync_q <= 1'b1;
    end else begin
      vsync_q <= vsync_i;
    end
  end

  assign rise_o = vsync_i & ~vsync_q;

endmodule

// File: rtl/cam_dmactrl.sv
// Capture-FIFO to VRAM frame writer: one frame of AXI4 INCR bursts per VSYNC.
// Optional CAM_DMA_BRESP_EN adds BRESP checking with a sticky BUS_ERR flag.
module cam_dmactrl
  import cam_pkg::*;
#(
  parameter int unsigned H_PIX     = 640,
  parameter int unsigned V_PIX     = 480,
  parameter int unsigned BURST_LEN = 16
) (
  input  logic        ACLK,
  input  logic        ARST,
  input  logic        CAM_VSYNC,
  input  logic        CAPON,
  input  logic [31:0] CAPADDR,
  input  logic [31:0] FIFO_DOUT,
  input  logic [11:0] FIFO_CNT,
  output logic        FIFO_RDEN,
  output logic        FIFO_CLR,
  output logic [31:0] AWADDR,
  output logic [7:0]  AWLEN,
  output logic        AWVALID,
  input  logic        AWREADY,
  output logic [31:0] WDATA,
  output logic        WLAST,
  output logic        WVALID,
  input  logic        WREADY,
  input  logic        BVALID,
  output logic        BREADY,
`ifdef CAM_DMA_BRESP_EN
  input  logic [1:0]  BRESP,
  output logic        BUS_ERR,
`endif
  output logic        end_of_screen,
  output logic        FIFOUNDER
);

  localparam int unsigned NumBursts = H_PIX * V_PIX / BURST_LEN;
  localparam int unsigned BurstW    = clog2_min1(NumBursts);
  localparam int unsigned BeatW     = clog2_min1(BURST_LEN);
  localparam int unsigned AddrShift = $clog2(BURST_LEN * BYTES_PER_WORD);

  localparam logic [BurstW-1:0] LastBurst = BurstW'(NumBursts - 1);
  localparam logic [BeatW-1:0]  LastBeat  = BeatW'(BURST_LEN - 1);

  logic vs_rise;

  cam_vsync_edge u_vsync_edge (
    .clk_i   (ACLK),
    .rst_i   (ARST),
    .vsync_i (CAM_VSYNC),
    .rise_o  (vs_rise)
  );

  cam_state_e        state_q, state_d;
  logic [31:0]       base_q, base_d;
  logic [BurstW-1:0] burst_idx_q, burst_idx_d;
  logic [BeatW-1:0]  beat_q, beat_d;
  logic              abort_q, abort_d;
  logic              fifo_clr_q, fifo_clr_d;
  logic              eos_q, eos_d;
  logic              under_q, under_d;
  logic              frame_start;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    burst_idx_d = burst_idx_q;
    beat_d      = beat_q;
    abort_d     = abort_q;
    fifo_clr_d  = 1'b0;
    eos_d       = 1'b0;
    under_d     = 1'b0;
    frame_start = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (vs_rise && CAPON) begin
          frame_start = 1'b1;
          base_d      = CAPADDR;
          burst_idx_d = '0;
          beat_d      = '0;
          abort_d     = 1'b0;
          fifo_clr_d  = 1'b1;
          state_d     = WAIT_DATA;
        end
      end

      WAIT_DATA: begin
        // No burst is in flight here, so an abort lands immediately.
        if (vs_rise) begin
          under_d    = 1'b1;
          fifo_clr_d = 1'b1;
          abort_d    = 1'b0;
          state_d    = IDLE;
        end else if (32'(FIFO_CNT) >= BURST_LEN) begin
          state_d = ADDR;
        end
      end

      ADDR: begin
        if (vs_rise) abort_d = 1'b1;
        if (AWREADY) begin
          beat_d  = '0;
          state_d = DATA;
        end
      end

      DATA: begin
        if (vs_rise) abort_d = 1'b1;
        if (WREADY) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == LastBeat) state_d = RESP;
        end
      end

      RESP: begin
        if (vs_rise) abort_d = 1'b1;
        if (BVALID) begin
          // A completed frame wins over an abort raised in its final burst.
          if (burst_idx_q == LastBurst) begin
            eos_d   = 1'b1;
            abort_d = 1'b0;
            state_d = IDLE;
          end else if (abort_q || vs_rise) begin
            under_d    = 1'b1;
            fifo_clr_d = 1'b1;
            abort_d    = 1'b0;
            state_d    = IDLE;
          end else begin
            burst_idx_d = burst_idx_q + 1'b1;
            state_d     = WAIT_DATA;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARST) begin
    if (ARST) begin
      state_q     <= IDLE;
      base_q      <= '0;
      burst_idx_q <= '0;
      beat_q      <= '0;
      abort_q     <= 1'b0;
      fifo_clr_q  <= 1'b0;
      eos_q       <= 1'b0;
      under_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      burst_idx_q <= burst_idx_d;
      beat_q      <= beat_d;
      abort_q     <= abort_d;
      fifo_clr_q  <= fifo_clr_d;
      eos_q       <= eos_d;
      under_q     <= under_d;
    end
  end

`ifdef CAM_DMA_BRESP_EN
  logic bus_err_q, bus_err_d;

  always_comb begin
    bus_err_d = bus_err_q;
    if (frame_start) begin
      bus_err_d = 1'b0;
    end else if ((state_q == RESP) && BVALID && (BRESP != RESP_OKAY)) begin
      bus_err_d = 1'b1;
    end
  end

  always_ff @(posedge ACLK or posedge ARST) begin
    if (ARST) begin
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= bus_err_d;
    end
  end

  assign BUS_ERR = bus_err_q;
`endif

  // Payloads derive from registered state only, so they hold while VALID waits.
  assign AWVALID       = (state_q == ADDR);
  assign AWADDR        = base_q + (32'(burst_idx_q) << AddrShift);
  assign AWLEN         = 8'(BURST_LEN - 1);
  assign WVALID        = (state_q == DATA);
  assign WDATA         = FIFO_DOUT;
  assign WLAST         = WVALID && (beat_q == LastBeat);
  assign BREADY        = (state_q == RESP);
  assign FIFO_RDEN     = WVALID && WREADY;
  assign FIFO_CLR      = fifo_clr_q;
  assign end_of_screen = eos_q;
  assign FIFOUNDER     = under_q;

endmodule

// File: tb/tb_cam_dmactrl.sv
// Directed scoreboard bench for cam_dmactrl with an 8x4 frame and 4-word bursts.
module tb_cam_dmactrl;

  localparam int unsigned HPix      = 8;
  localparam int unsigned VPix      = 4;
  localparam int unsigned BurstLen  = 4;
  localparam int unsigned NumBursts = HPix * VPix / BurstLen;

  logic        ACLK;
  logic        ARST;
  logic        CAM_VSYNC;
  logic        CAPON;
  logic [31:0] CAPADDR;
  logic [31:0] FIFO_DOUT;
  logic [11:0] FIFO_CNT;
  logic        FIFO_RDEN;
  logic        FIFO_CLR;
  logic [31:0] AWADDR;
  logic [7:0]  AWLEN;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic        WLAST;
  logic        WVALID;
  logic        WREADY;
  logic        BVALID;
  logic        BREADY;
`ifdef CAM_DMA_BRESP_EN
  logic [1:0]  BRESP;
  logic        BUS_ERR;
`endif
  logic        end_of_screen;
  logic        FIFOUNDER;

  cam_dmactrl #(
    .H_PIX     (HPix),
    .V_PIX     (VPix),
    .BURST_LEN (BurstLen)
  ) dut (
    .ACLK          (ACLK),
    .ARST          (ARST),
    .CAM_VSYNC     (CAM_VSYNC),
    .CAPON         (CAPON),
    .CAPADDR       (CAPADDR),
    .FIFO_DOUT     (FIFO_DOUT),
    .FIFO_CNT      (FIFO_CNT),
    .FIFO_RDEN     (FIFO_RDEN),
    .FIFO_CLR      (FIFO_CLR),
    .AWADDR        (AWADDR),
    .AWLEN         (AWLEN),
    .AWVALID       (AWVALID),
    .AWREADY       (AWREADY),
    .WDATA         (WDATA),
    .WLAST         (WLAST),
    .WVALID        (WVALID),
    .WREADY        (WREADY),
    .BVALID        (BVALID),
    .BREADY        (BREADY),
`ifdef CAM_DMA_BRESP_EN
    .BRESP         (BRESP),
    .BUS_ERR       (BUS_ERR),
`endif
    .end_of_screen (end_of_screen),
    .FIFOUNDER     (FIFOUNDER)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int n_aw, n_w, n_eos, n_under, n_clr, n_rden;
  int frame_aw, frame_w, frame_b;
  logic rand_mode;
  logic bresp_err_en;
  int fifo_rd;
  int b_pend;

  logic [31:0] exp_aw_q[$];
  logic [31:0] exp_w_q[$];

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge ACLK);
    #1;
  endtask

  task automatic pulse_vsync();
    CAM_VSYNC = 1'b1;
    step(1);
    CAM_VSYNC = 1'b0;
    step(1);
  endtask

  // Expected AW addresses and W words for the bursts this frame should issue.
  task automatic push_frame(input logic [31:0] base, input int bursts);
    for (int b = 0; b < bursts; b++) exp_aw_q.push_back(base + 32'(b * BurstLen * 4));
    for (int i = 0; i < bursts * int'(BurstLen); i++)
      exp_w_q.push_back(32'hA000_0000 + 32'(fifo_rd + i));
  endtask

  task automatic wait_eos(input int target, input int budget);
    int k = 0;
    while (n_eos < target && k < budget) begin
      step(1);
      k++;
    end
    check("eos_wait", 32'(n_eos >= target), 32'd1);
  endtask

  // Slave side: FWFT FIFO head, READY generation, one B per completed burst.
  initial begin
    logic s_wlast, s_b, s_rd;
    AWREADY   = 1'b0;
    WREADY    = 1'b0;
    BVALID    = 1'b0;
    fifo_rd   = 0;
    b_pend    = 0;
    FIFO_DOUT = 32'hA000_0000;
`ifdef CAM_DMA_BRESP_EN
    BRESP = 2'b00;
`endif
    forever begin
      @(negedge ACLK);
      s_wlast = WVALID && WREADY && WLAST;
      s_b     = BVALID && BREADY;
      s_rd    = FIFO_RDEN;
      @(posedge ACLK);
      #1;
      if (ARST) begin
        b_pend = 0;
      end else begin
        if (s_wlast) b_pend++;
        if (s_b) b_pend--;
        if (s_rd) fifo_rd++;
      end
      AWREADY   = rand_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
      WREADY    = rand_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
      BVALID    = (b_pend > 0) && (rand_mode ? ($urandom_range(0, 1) == 1) : 1'b1);
      FIFO_DOUT = 32'hA000_0000 + 32'(fifo_rd);
`ifdef CAM_DMA_BRESP_EN
      BRESP = (bresp_err_en && BVALID && frame_b == 2) ? 2'b10 : 2'b00;
`endif
    end
  end

  // Monitor: scoreboard pops on handshakes, VALID/payload stability, pulse timing.
  initial begin
    logic        exp_eos, p_awv, p_awr, p_wv, p_wr, p_wlast;
    logic [31:0] p_awaddr, p_wdata;
    n_aw = 0; n_w = 0; n_eos = 0; n_under = 0; n_clr = 0; n_rden = 0;
    frame_aw = 0; frame_w = 0; frame_b = 0;
    exp_eos = 1'b0; p_awv = 1'b0; p_awr = 1'b0; p_wv = 1'b0; p_wr = 1'b0; p_wlast = 1'b0;
    p_awaddr = '0; p_wdata = '0;
    forever begin
      @(negedge ACLK);
      if (ARST) begin
        frame_aw = 0; frame_w = 0; frame_b = 0;
        exp_eos = 1'b0; p_awv = 1'b0; p_wv = 1'b0;
      end else begin
        if (p_awv && !p_awr) begin
          check("awvalid_hold", 32'(AWVALID), 32'd1);
          check("awaddr_stable", AWADDR, p_awaddr);
        end
        if (p_wv && !p_wr) begin
          check("wvalid_hold", 32'(WVALID), 32'd1);
          check("wdata_stable", WDATA, p_wdata);
          check("wlast_stable", 32'(WLAST), 32'(p_wlast));
        end
        check("eos_timing", 32'(end_of_screen), 32'(exp_eos));
        exp_eos = 1'b0;
        check("rden_is_w_handshake", 32'(FIFO_RDEN), 32'(WVALID && WREADY));
        if (FIFOUNDER) check("under_with_clr", 32'(FIFO_CLR), 32'd1);
        if (end_of_screen) n_eos++;
        if (FIFOUNDER) n_under++;
        if (FIFO_RDEN) n_rden++;
        if (FIFO_CLR) begin
          n_clr++;
          frame_aw = 0; frame_w = 0; frame_b = 0;
        end
        if (AWVALID && AWREADY) begin
          check("aw_expected", 32'(exp_aw_q.size() > 0), 32'd1);
          if (exp_aw_q.size() > 0) check("awaddr", AWADDR, exp_aw_q.pop_front());
          check("awlen", 32'(AWLEN), 32'(BurstLen - 1));
          n_aw++;
          frame_aw++;
        end
        if (WVALID && WREADY) begin
          check("w_expected", 32'(exp_w_q.size() > 0), 32'd1);
          if (exp_w_q.size() > 0) check("wdata", WDATA, exp_w_q.pop_front());
          check("wlast", 32'(WLAST), 32'((frame_w % BurstLen) == BurstLen - 1));
          n_w++;
          frame_w++;
        end
        if (BVALID && BREADY) begin
          frame_b++;
          if (frame_b == NumBursts) exp_eos = 1'b1;
        end
        p_awv = AWVALID; p_awr = AWREADY; p_awaddr = AWADDR;
        p_wv = WVALID; p_wr = WREADY; p_wdata = WDATA; p_wlast = WLAST;
      end
    end
  end

  initial begin
    int k;
    int rden0;
    ARST         = 1'b1;
    CAM_VSYNC    = 1'b1;
    CAPON        = 1'b1;
    CAPADDR      = 32'h1000_0000;
    FIFO_CNT     = 12'd0;
    rand_mode    = 1'b0;
    bresp_err_en = 1'b0;

    #12;
    check("rst_awvalid", 32'(AWVALID), 32'd0);
    check("rst_wvalid", 32'(WVALID), 32'd0);
    check("rst_wlast", 32'(WLAST), 32'd0);
    check("rst_bready", 32'(BREADY), 32'd0);
    check("rst_rden", 32'(FIFO_RDEN), 32'd0);
    check("rst_clr", 32'(FIFO_CLR), 32'd0);
    check("rst_eos", 32'(end_of_screen), 32'd0);
    check("rst_under", 32'(FIFOUNDER), 32'd0);
    check("rst_awaddr", AWADDR, 32'd0);
    check("rst_awlen", 32'(AWLEN), 32'(BurstLen - 1));
`ifdef CAM_DMA_BRESP_EN
    check("rst_bus_err", 32'(BUS_ERR), 32'd0);
`endif
    @(posedge ACLK);
    #1;
    ARST = 1'b0;
    // VSYNC already high across reset must not look like an edge.
    step(5);
    check("no_start_vsync_high_at_reset", 32'(n_clr), 32'd0);
    CAM_VSYNC = 1'b0;
    step(2);

    // Full frame with everything ready.
    FIFO_CNT = 12'd16;
    push_frame(32'h1000_0000, NumBursts);
    pulse_vsync();
    wait_eos(1, 400);
    step(3);
    check("f1_aw_count", 32'(n_aw), 32'd8);
    check("f1_eos_count", 32'(n_eos), 32'd1);
    check("f1_clr_count", 32'(n_clr), 32'd1);
    check("f1_rden_count", 32'(n_rden), 32'd32);
    check("f1_aw_queue_empty", 32'(exp_aw_q.size()), 32'd0);
    check("f1_w_queue_empty", 32'(exp_w_q.size()), 32'd0);

    // CAPON low at VSYNC: nothing starts.
    CAPON = 1'b0;
    pulse_vsync();
    step(20);
    check("capon0_no_clr", 32'(n_clr), 32'd1);
    check("capon0_no_aw", 32'(n_aw), 32'd8);
    CAPON = 1'b1;

    // Starved FIFO, then an abort from WAIT_DATA.
    FIFO_CNT = 12'd3;
    pulse_vsync();
    step(20);
    check("starved_clr", 32'(n_clr), 32'd2);
    check("starved_no_aw", 32'(n_aw), 32'd8);
    check("starved_awvalid", 32'(AWVALID), 32'd0);
    pulse_vsync();
    step(3);
    check("wait_abort_under", 32'(n_under), 32'd1);
    check("wait_abort_clr", 32'(n_clr), 32'd3);

    // Restart at burst 0; AW latency from FIFO level; CAPADDR change deferred.
    CAPADDR = 32'h2000_0000;
    push_frame(32'h2000_0000, NumBursts);
    pulse_vsync();
    CAPADDR = 32'h5555_0000;
    step(2);
    check("restart_clr", 32'(n_clr), 32'd4);
    check("aw_low_while_starved", 32'(AWVALID), 32'd0);
    FIFO_CNT = 12'd16;
    check("aw_low_same_cycle", 32'(AWVALID), 32'd0);
    step(1);
    check("aw_latency", 32'(AWVALID), 32'd1);
    wait_eos(2, 400);
    check("f2_aw_queue_empty", 32'(exp_aw_q.size()), 32'd0);
    check("f2_under_unchanged", 32'(n_under), 32'd1);

    // Abort during beat 2 of burst 5: burst finishes, no burst 6.
    CAPADDR = 32'h3000_0000;
    push_frame(32'h3000_0000, 6);
    pulse_vsync();
    k = 0;
    while (frame_w < 22 && k < 300) begin
      step(1);
      k++;
    end
    check("reach_burst5_beat2", 32'(frame_w), 32'd22);
    CAM_VSYNC = 1'b1;
    step(1);
    CAM_VSYNC = 1'b0;
    k = 0;
    while (n_under < 2 && k < 100) begin
      step(1);
      k++;
    end
    step(10);
    check("burst_abort_under", 32'(n_under), 32'd2);
    check("burst_abort_no_eos", 32'(n_eos), 32'd2);
    check("burst_abort_frame_aw", 32'(frame_aw), 32'd0);
    check("burst_abort_aw_total", 32'(n_aw), 32'd22);
    check("burst_abort_aw_queue", 32'(exp_aw_q.size()), 32'd0);
    check("burst_abort_w_queue", 32'(exp_w_q.size()), 32'd0);

    // Random stalls with an address that wraps past 2^32.
    rand_mode = 1'b1;
    CAPADDR = 32'hFFFF_FFC0;
    push_frame(32'hFFFF_FFC0, NumBursts);
    rden0 = n_rden;
    pulse_vsync();
    wait_eos(3, 3000);
    rand_mode = 1'b0;
    step(5);
    check("rand_rden_per_frame", 32'(n_rden - rden0), 32'd32);
    check("rand_aw_queue", 32'(exp_aw_q.size()), 32'd0);
    check("rand_w_queue", 32'(exp_w_q.size()), 32'd0);

`ifdef CAM_DMA_BRESP_EN
    // Error response on burst 2: sticky until the next frame starts.
    bresp_err_en = 1'b1;
    CAPADDR = 32'h0600_0000;
    push_frame(32'h0600_0000, NumBursts);
    pulse_vsync();
    k = 0;
    while (frame_b < 2 && k < 300) begin
      step(1);
      k++;
    end
    check("bus_err_before", 32'(BUS_ERR), 32'd0);
    while (frame_b < 3 && k < 300) begin
      step(1);
      k++;
    end
    check("bus_err_set", 32'(BUS_ERR), 32'd1);
    wait_eos(4, 400);
    step(2);
    check("bus_err_sticky", 32'(BUS_ERR), 32'd1);
    bresp_err_en = 1'b0;
    push_frame(32'h0600_0000, NumBursts);
    pulse_vsync();
    check("bus_err_cleared", 32'(BUS_ERR), 32'd0);
    wait_eos(5, 400);
    step(3);
`endif

    // Asynchronous reset in the middle of a data burst.
    CAPADDR = 32'h0700_0000;
    push_frame(32'h0700_0000, NumBursts);
    pulse_vsync();
    k = 0;
    while (frame_w < 2 && k < 300) begin
      step(1);
      k++;
    end
    check("pre_rst_wvalid", 32'(WVALID), 32'd1);
    #2;
    ARST = 1'b1;
    #1;
    check("arst_wvalid", 32'(WVALID), 32'd0);
    check("arst_rden", 32'(FIFO_RDEN), 32'd0);
    check("arst_wlast", 32'(WLAST), 32'd0);
    check("arst_awvalid", 32'(AWVALID), 32'd0);
    check("arst_awaddr", AWADDR, 32'd0);
    exp_aw_q.delete();
    exp_w_q.delete();
    step(2);
    ARST = 1'b0;
    step(3);
    check("post_rst_bready", 32'(BREADY), 32'd0);
    check("post_rst_clr", 32'(FIFO_CLR), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
